// File: rtl/seg_scan_if.sv
// Bundle of the scan controller's data-side signals: display value and controls in,
// digit enables plus nibble/blank toward the segment decoder out.
interface seg_scan_if;
    logic        en;
    logic        freeze;
    logic        lzb_en;
    logic [2:0]  bright;
    logic [31:0] Leddata;
    logic [7:0]  AN;
    logic [3:0]  code;
    logic        blank;
    logic [2:0]  digit;
    logic        frame_done;

    modport master (
        output en, freeze, lzb_en, bright, Leddata,
        input  AN, code, blank, digit, frame_done
    );

    modport slave (
        input  en, freeze, lzb_en, bright, Leddata,
        output AN, code, blank, digit, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: frame-latched data, per-digit PWM brightness
// in eight slots, optional leading-zero blanking, registered outputs one cycle behind state.
module seg_scan_ctrl #(
    parameter int SLOT_LEN = 9375
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int              PRE_W   = $clog2(SLOT_LEN);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SLOT_LEN - 1);

    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_slot;
    logic [2:0]       r_idx;
    logic [2:0]       r_bri_q;
    logic [31:0]      r_frame;

    logic [7:0]       r_an;
    logic [3:0]       r_code;
    logic             r_blank;
    logic [2:0]       r_digit;
    logic             r_frame_done;

    logic             w_slot_end;
    logic             w_digit_end;
    logic             w_frame_end;
    logic [3:0]       w_nibble;
    logic             w_upper_zero;
    logic             w_lzb_blank;
    logic             w_lit;
    logic [7:0]       w_an_lit;

    assign w_slot_end   = (r_pre == PRE_MAX);
    assign w_digit_end  = w_slot_end && (r_slot == 3'd7);
    assign w_frame_end  = w_digit_end && (r_idx == 3'd7);
    assign w_nibble     = r_frame[{r_idx, 2'b00} +: 4];
    // Nibbles idx..7 all zero means this digit is a leading zero.
    assign w_upper_zero = ((r_frame >> {r_idx, 2'b00}) == 32'd0);
    assign w_lzb_blank  = bus.lzb_en && (r_idx != 3'd0) && w_upper_zero;
    assign w_lit        = (r_slot <= r_bri_q) && !w_lzb_blank;
    assign w_an_lit     = ~(8'h80 >> r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_slot  <= 3'd0;
            r_idx   <= 3'd0;
            r_bri_q <= 3'd0;
            r_frame <= 32'd0;
        end else if (!bus.en) begin
            r_pre   <= '0;
            r_slot  <= 3'd0;
            r_idx   <= 3'd0;
            r_bri_q <= bus.bright;
            r_frame <= bus.Leddata;
        end else begin
            if (w_slot_end) begin
                r_pre  <= '0;
                r_slot <= r_slot + 3'd1;
            end else begin
                r_pre  <= r_pre + PRE_W'(1);
            end
            // Brightness and frame data only move at digit/frame edges so nothing tears.
            if (w_digit_end) begin
                r_idx   <= r_idx + 3'd1;
                r_bri_q <= bus.bright;
                if (w_frame_end && !bus.freeze) begin
                    r_frame <= bus.Leddata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= 8'hFF;
            r_code       <= 4'd0;
            r_blank      <= 1'b1;
            r_digit      <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_digit      <= r_idx;
            r_code       <= w_nibble;
            r_frame_done <= bus.en && w_frame_end;
            if (bus.en) begin
                r_an    <= w_lit ? w_an_lit : 8'hFF;
                r_blank <= !w_lit;
            end else begin
                r_an    <= 8'hFF;
                r_blank <= 1'b1;
            end
        end
    end

    assign bus.AN         = r_an;
    assign bus.code       = r_code;
    assign bus.blank      = r_blank;
    assign bus.digit      = r_digit;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a single-counter reference model of the scan timing.
module tb_seg_scan_ctrl;
    localparam int SL    = 2;
    localparam int DIG   = 8 * SL;
    localparam int FRAME = 64 * SL;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seg_scan_if bus ();

    seg_scan_ctrl #(.SLOT_LEN(SL)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [16:0] dut_out = {bus.AN, bus.code, bus.blank, bus.digit, bus.frame_done};

    // Reference model: one counter of cycles since the frame started.
    int          m_cnt;
    logic [31:0] m_frame;
    logic [2:0]  m_bri;
    logic [16:0] m_out;
    int          m_k;
    int          m_s;
    logic [31:0] m_up;
    logic        m_lit;
    logic [7:0]  m_an_on;

    always_comb begin
        m_k     = m_cnt / DIG;
        m_s     = (m_cnt / SL) % 8;
        m_up    = m_frame >> (4 * m_k);
        m_lit   = (m_s <= int'(m_bri)) && !(bus.lzb_en && (m_k != 0) && (m_up == 32'd0));
        m_an_on = 8'hFF;
        m_an_on[7 - m_k] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_frame <= 32'd0;
            m_bri   <= 3'd0;
            m_out   <= {8'hFF, 4'h0, 1'b1, 3'd0, 1'b0};
        end else if (!bus.en) begin
            m_cnt   <= 0;
            m_frame <= bus.Leddata;
            m_bri   <= bus.bright;
            m_out   <= {8'hFF, m_up[3:0], 1'b1, 3'(m_k), 1'b0};
        end else begin
            m_out <= {m_lit ? m_an_on : 8'hFF, m_up[3:0], !m_lit, 3'(m_k), (m_cnt == FRAME - 1)};
            if ((m_cnt % DIG) == DIG - 1) m_bri <= bus.bright;
            if ((m_cnt == FRAME - 1) && !bus.freeze) m_frame <= bus.Leddata;
            m_cnt <= (m_cnt + 1) % FRAME;
        end
    end

    task automatic test_reset();
        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.freeze  = 1'b0;
        bus.lzb_en  = 1'b0;
        bus.bright  = 3'd7;
        bus.Leddata = $urandom;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_out !== {8'hFF, 4'h0, 1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required %h", dut_out, {8'hFF, 4'h0, 1'b1, 3'd0, 1'b0});
        end
        n_checks++;
        if (dut_out !== m_out) begin
            n_fail++;
            $display("FAIL reset_model: got %h required %h", dut_out, m_out);
        end
    endtask

    task automatic test_sweep();
        bus.Leddata = 32'h8765_4321;
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL sweep_model cyc %0d: got %h required %h", c, dut_out, m_out);
            end
            if (c == FRAME - 1) begin
                n_checks++;
                if (bus.frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_frame_done cyc %0d: got %b required 1", c, bus.frame_done);
                end
            end
            if (c < FRAME) begin
                n_checks++;
                if (bus.code !== 4'h0) begin
                    n_fail++;
                    $display("FAIL sweep_code_first cyc %0d: got %h required 0", c, bus.code);
                end
            end else if (c < 2 * FRAME) begin
                n_checks++;
                if (bus.code !== 4'((c - FRAME) / DIG + 1)) begin
                    n_fail++;
                    $display("FAIL sweep_code_second cyc %0d: got %h required %h", c, bus.code, 4'((c - FRAME) / DIG + 1));
                end
            end
        end
    endtask

    task automatic test_brightness();
        int lit;
        bit found;
        bus.bright = 3'd1;
        for (int pass = 0; pass < 2; pass++) begin
            lit = 0;
            for (int c = 0; c < 2 * DIG + 4 * DIG; c++) begin
                @(negedge clk);
                n_checks++;
                if (dut_out !== m_out) begin
                    n_fail++;
                    $display("FAIL bright_model cyc %0d: got %h required %h", c, dut_out, m_out);
                end
                if (c >= 2 * DIG && bus.AN !== 8'hFF) lit++;
            end
            n_checks++;
            if (lit != (pass == 0 ? 16 : 32)) begin
                n_fail++;
                $display("FAIL bright_lit_count pass %0d: got %0d required %0d", pass, lit, (pass == 0 ? 16 : 32));
            end
            if (pass == 0) begin
                found = 1'b0;
                for (int c = 0; c < 2 * DIG && !found; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (dut_out !== m_out) begin
                        n_fail++;
                        $display("FAIL bright_wait_model cyc %0d: got %h required %h", c, dut_out, m_out);
                    end
                    if ((m_cnt % DIG) == 5) found = 1'b1;
                end
                n_checks++;
                if (!found) begin
                    n_fail++;
                    $display("FAIL bright_mid_digit_wait: got timeout required mid-digit point");
                end
                bus.bright = 3'd3;
            end
        end
    endtask

    task automatic test_lzb();
        int lit_cnt [8];
        logic [3:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            bus.lzb_en  = 1'b1;
            bus.bright  = 3'd7;
            bus.Leddata = (pass == 0) ? 32'h0000_0A05 : 32'h0;
            bus.en      = 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL lzb_disable_model: got %h required %h", dut_out, m_out);
            end
            bus.en = 1'b1;
            for (int d = 0; d < 8; d++) lit_cnt[d] = 0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                n_checks++;
                if (dut_out !== m_out) begin
                    n_fail++;
                    $display("FAIL lzb_model cyc %0d: got %h required %h", c, dut_out, m_out);
                end
                if (bus.AN !== 8'hFF) begin
                    lit_cnt[bus.digit]++;
                    want = (pass == 1 || bus.digit == 3'd1) ? 4'h0 : (bus.digit == 3'd0) ? 4'h5 : 4'hA;
                    n_checks++;
                    if (bus.code !== want) begin
                        n_fail++;
                        $display("FAIL lzb_code digit %0d: got %h required %h", bus.digit, bus.code, want);
                    end
                end
            end
            for (int d = 0; d < 8; d++) begin
                n_checks++;
                if (lit_cnt[d] != ((d <= (pass == 0 ? 2 : 0)) ? DIG : 0)) begin
                    n_fail++;
                    $display("FAIL lzb_lit digit %0d pass %0d: got %0d required %0d", d, pass, lit_cnt[d], ((d <= (pass == 0 ? 2 : 0)) ? DIG : 0));
                end
            end
        end
        bus.lzb_en = 1'b0;
    endtask

    task automatic test_freeze();
        int fd_cnt;
        bus.Leddata = 32'h1111_1111;
        bus.en      = 1'b0;
        @(negedge clk);
        bus.en      = 1'b1;
        bus.freeze  = 1'b1;
        bus.Leddata = 32'h2222_2222;
        fd_cnt = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out || bus.code !== 4'h1) begin
                n_fail++;
                $display("FAIL freeze_hold cyc %0d: got %h required %h with code 1", c, dut_out, m_out);
            end
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
        n_checks++;
        if (fd_cnt != 3) begin
            n_fail++;
            $display("FAIL freeze_frame_done_count: got %0d required 3", fd_cnt);
        end
        bus.freeze = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out || bus.code !== (c < FRAME ? 4'h1 : 4'h2)) begin
                n_fail++;
                $display("FAIL freeze_release cyc %0d: got %h code %h required %h code %h", c, dut_out, bus.code, m_out, (c < FRAME ? 4'h1 : 4'h2));
            end
        end
    endtask

    task automatic test_en_rst();
        logic [31:0] val;
        bit found;
        for (int step = 0; step < 2; step++) begin
            found = 1'b0;
            for (int c = 0; c < 2 * FRAME && !found; c++) begin
                @(negedge clk);
                n_checks++;
                if (dut_out !== m_out) begin
                    n_fail++;
                    $display("FAIL enrst_wait_model cyc %0d: got %h required %h", c, dut_out, m_out);
                end
                if (m_cnt == (step == 0 ? 4 * DIG + 5 : 5 * DIG + 3 * SL)) found = 1'b1;
            end
            n_checks++;
            if (!found || bus.digit !== (step == 0 ? 3'd4 : 3'd5)) begin
                n_fail++;
                $display("FAIL enrst_position step %0d: got digit %0d found %0d required digit %0d", step, bus.digit, found, (step == 0 ? 4 : 5));
            end
            if (step == 0) begin
                bus.en = 1'b0;
                @(negedge clk);
                n_checks++;
                if (bus.AN !== 8'hFF || bus.blank !== 1'b1 || dut_out !== m_out) begin
                    n_fail++;
                    $display("FAIL en_drop: got AN %h blank %b required AN ff blank 1", bus.AN, bus.blank);
                end
                val = $urandom;
                bus.Leddata = val;
                repeat (2) @(negedge clk);
                bus.en = 1'b1;
                @(negedge clk);
                n_checks++;
                if (bus.digit !== 3'd0 || bus.code !== val[3:0] || dut_out !== m_out) begin
                    n_fail++;
                    $display("FAIL en_restart: got digit %0d code %h required digit 0 code %h", bus.digit, bus.code, val[3:0]);
                end
            end else begin
                rst = 1'b1;
                @(negedge clk);
                n_checks++;
                if (dut_out !== {8'hFF, 4'h0, 1'b1, 3'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rst_mid_digit: got %h required %h", dut_out, {8'hFF, 4'h0, 1'b1, 3'd0, 1'b0});
                end
                rst = 1'b0;
                bus.Leddata = $urandom | 32'h1;
                for (int c = 0; c < DIG; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (dut_out !== m_out || bus.code !== 4'h0) begin
                        n_fail++;
                        $display("FAIL rst_frame_zero cyc %0d: got %h required %h with code 0", c, dut_out, m_out);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_out !== m_out) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h required %h", c, dut_out, m_out);
            end
            n_checks++;
            if ($countones(~bus.AN) > 1 || (bus.blank === 1'b1 && bus.AN !== 8'hFF)) begin
                n_fail++;
                $display("FAIL random_an_blank cyc %0d: got AN %h blank %b required one-hot-low AN, dark when blank", c, bus.AN, bus.blank);
            end
            if ($urandom_range(0, 49) == 0) bus.Leddata = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 39) == 0) bus.bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) bus.lzb_en = ~bus.lzb_en;
            if ($urandom_range(0, 149) == 0) bus.freeze = ~bus.freeze;
            if (bus.en) begin
                if ($urandom_range(0, 299) == 0) bus.en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.en = 1'b1;
            end
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_brightness();
        test_lzb();
        test_freeze();
        test_en_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
